fp_norm_shifter: RTL and testbench

Multi-cycle normalization shifter for the FP divider datapath. It consumes the 1-based leading-one position produced by the leading-one counter, left-shifts the mantissa so its MSB is set, and debits the exponent by the applied shift. It sits between the quotient/leading-one stage and rounding, with valid/ready handshakes on both sides.

---
 rtl/fp_norm_shifter_if.sv | 29 ++
 rtl/fp_norm_shifter.sv | 113 +++++++++++
 tb/tb_fp_norm_shifter.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/fp_norm_shifter_if.sv
// Handshake bundle for the FP normalization shifter: upstream beat in, normalized result out.
// The slave modport is the shifter's view; master is the driver/consumer side.
interface fp_norm_shifter_if #(
   parameter int N  = 24,
   parameter int EW = 8,
   parameter int CW = $clog2(N + 1)
);
   logic          in_valid;
   logic          in_ready;
   logic [N-1:0]  in_mant;
   logic [EW-1:0] in_exp;
   logic [CW-1:0] in_cnt;
   logic          out_valid;
   logic          out_ready;
   logic [N-1:0]  out_mant;
   logic [EW-1:0] out_exp;
   logic          out_zero;
   logic          out_uflow;

   modport master (
      output in_valid, in_mant, in_exp, in_cnt, out_ready,
      input  in_ready, out_valid, out_mant, out_exp, out_zero, out_uflow
   );

   modport slave (
      input  in_valid, in_mant, in_exp, in_cnt, out_ready,
      output in_ready, out_valid, out_mant, out_exp, out_zero, out_uflow
   );
endinterface

// File: rtl/fp_norm_shifter.sv
// Multi-cycle normalization shifter: one log-shifter stage per cycle driven by the
// leading-one count, then a saturating exponent debit when the result is registered.
module fp_norm_shifter #(
   parameter int N  = 24,
   parameter int EW = 8,
   parameter int CW = $clog2(N + 1)
) (
   input logic              clk,
   input logic              rst_n,
   fp_norm_shifter_if.slave bus
);
   localparam int KW = (CW > 1) ? $clog2(CW) : 1;

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t        r_state;
   logic [N-1:0]  r_mant;
   logic [EW-1:0] r_exp;
   logic [CW-1:0] r_s;
   logic          r_zero;
   logic [KW-1:0] r_k;

   logic [N-1:0]  r_outMant;
   logic [EW-1:0] r_outExp;
   logic          r_outValid;
   logic          r_outZero;
   logic          r_outUflow;

   logic          w_cntOk;
   logic [N-1:0]  w_shifted;
   logic [EW:0]   w_expWide;
   logic [EW:0]   w_sWide;
   logic [EW:0]   w_expDiff;

   // Stage k shifts by 2^k when bit k of the shift amount is set; the exponent
   // compare is widened by one bit so in_exp <= s is an unsigned test.
   always_comb begin
      w_cntOk   = (bus.in_cnt != '0) && (bus.in_cnt <= CW'(N));
      w_shifted = r_mant;
      if (r_s[r_k]) begin
         w_shifted = r_mant << (1 << r_k);
      end
      w_expWide = {1'b0, r_exp};
      w_sWide   = (EW + 1)'(r_s);
      w_expDiff = w_expWide - w_sWide;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_mant     <= '0;
         r_exp      <= '0;
         r_s        <= '0;
         r_zero     <= 1'b0;
         r_k        <= '0;
         r_outMant  <= '0;
         r_outExp   <= '0;
         r_outValid <= 1'b0;
         r_outZero  <= 1'b0;
         r_outUflow <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (bus.in_valid) begin
                  r_mant  <= bus.in_mant;
                  r_exp   <= bus.in_exp;
                  r_zero  <= !w_cntOk;
                  r_s     <= w_cntOk ? (bus.in_cnt - CW'(1)) : '0;
                  r_k     <= '0;
                  r_state <= SHIFT;
               end
            end
            SHIFT: begin
               r_mant <= w_shifted;
               r_k    <= r_k + 1'b1;
               // The last stage lands directly in the output registers.
               if (r_k == KW'(CW - 1)) begin
                  r_state    <= DONE;
                  r_outValid <= 1'b1;
                  r_outZero  <= r_zero;
                  if (r_zero) begin
                     r_outMant  <= '0;
                     r_outExp   <= '0;
                     r_outUflow <= 1'b0;
                  end else if (w_expWide <= w_sWide) begin
                     r_outMant  <= w_shifted;
                     r_outExp   <= '0;
                     r_outUflow <= 1'b1;
                  end else begin
                     r_outMant  <= w_shifted;
                     r_outExp   <= w_expDiff[EW-1:0];
                     r_outUflow <= 1'b0;
                  end
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  r_state    <= IDLE;
                  r_outValid <= 1'b0;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.in_ready  = (r_state == IDLE);
   assign bus.out_valid = r_outValid;
   assign bus.out_mant  = r_outMant;
   assign bus.out_exp   = r_outExp;
   assign bus.out_zero  = r_outZero;
   assign bus.out_uflow = r_outUflow;
endmodule

// File: tb/tb_fp_norm_shifter.sv
// Bench for fp_norm_shifter: directed corner cases, backpressure, mid-shift reset and
// random beats compared against an arithmetic model of normalization.
module tb_fp_norm_shifter;
   localparam int N  = 24;
   localparam int EW = 8;
   localparam int CW = 5;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   checkCount = 0;
   int   passCount  = 0;
   int   failCount  = 0;

   fp_norm_shifter_if #(.N(N), .EW(EW), .CW(CW)) bus ();

   fp_norm_shifter #(.N(N), .EW(EW), .CW(CW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      assert (observed === expected) begin
         passCount++;
      end else begin
         failCount++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   // Normalization as arithmetic: multiply by 2^(cnt-1), keep N bits, subtract from exponent.
   function automatic void refModel(input logic [N-1:0] m, input int e, input int c,
                                    output logic [N-1:0] em, output int ee,
                                    output bit ez, output bit eu);
      longint full;
      int     s;
      if (c < 1 || c > N) begin
         em = '0; ee = 0; ez = 1'b1; eu = 1'b0;
      end else begin
         s    = c - 1;
         full = longint'(m) * (longint'(1) << s);
         em   = N'(full % (longint'(1) << N));
         ez   = 1'b0;
         if (e - s <= 0) begin
            ee = 0; eu = 1'b1;
         end else begin
            ee = e - s; eu = 1'b0;
         end
      end
   endfunction

   function automatic int leadCount(input logic [N-1:0] m);
      for (int i = N - 1; i >= 0; i--) begin
         if (m[i]) return N - i;
      end
      return 0;
   endfunction

   task automatic applyStimulus(input logic [N-1:0] m, input int e, input int c,
                                input int holdCycles, input string tag);
      logic [N-1:0] em;
      int           ee;
      bit           ez;
      bit           eu;
      int           lat;
      refModel(m, e, c, em, ee, ez, eu);

      @(negedge clk);
      checkOutput({tag, "_inReadyIdle"}, 32'(bus.in_ready), 32'd1);
      bus.in_valid = 1'b1;
      bus.in_mant  = m;
      bus.in_exp   = EW'(e);
      bus.in_cnt   = CW'(c);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      lat = 0;
      while (!bus.out_valid && lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
      end
      checkOutput({tag, "_latency"}, 32'(lat), 32'(CW));
      checkOutput({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
      checkOutput({tag, "_mant"}, 32'(bus.out_mant), 32'(em));
      checkOutput({tag, "_exp"}, 32'(bus.out_exp), 32'(ee));
      checkOutput({tag, "_zero"}, 32'(bus.out_zero), 32'(ez));
      checkOutput({tag, "_uflow"}, 32'(bus.out_uflow), 32'(eu));

      // Offer a competing beat while stalled; it must neither disturb nor be taken.
      for (int h = 0; h < holdCycles; h++) begin
         @(negedge clk);
         bus.in_valid = 1'b1;
         bus.in_mant  = ~m;
         bus.in_exp   = EW'(e + 1);
         bus.in_cnt   = CW'(1);
         @(posedge clk);
         #1;
         checkOutput({tag, "_holdValid"}, 32'(bus.out_valid), 32'd1);
         checkOutput({tag, "_holdMant"}, 32'(bus.out_mant), 32'(em));
         checkOutput({tag, "_holdExp"}, 32'(bus.out_exp), 32'(ee));
         checkOutput({tag, "_holdInReady"}, 32'(bus.in_ready), 32'd0);
      end

      @(negedge clk);
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      checkOutput({tag, "_xferValid"}, 32'(bus.out_valid), 32'd0);
      checkOutput({tag, "_xferInReady"}, 32'(bus.in_ready), 32'd1);
      checkOutput({tag, "_xferMantHeld"}, 32'(bus.out_mant), 32'(em));
      @(negedge clk);
      bus.out_ready = 1'b0;
   endtask

   initial begin
      logic [N-1:0] rm;
      int           rc;
      int           re;
      int           seenValid;

      bus.in_valid  = 1'b0;
      bus.in_mant   = '0;
      bus.in_exp    = '0;
      bus.in_cnt    = '0;
      bus.out_ready = 1'b0;

      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("rst_inReady", 32'(bus.in_ready), 32'd1);
      checkOutput("rst_outValid", 32'(bus.out_valid), 32'd0);
      checkOutput("rst_mant", 32'(bus.out_mant), 32'd0);
      checkOutput("rst_exp", 32'(bus.out_exp), 32'd0);
      checkOutput("rst_zero", 32'(bus.out_zero), 32'd0);
      checkOutput("rst_uflow", 32'(bus.out_uflow), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      applyStimulus(24'h800000, 127, 1, 0, "normalized");
      applyStimulus(24'h000001, 100, 24, 0, "maxShift");
      applyStimulus(24'h00C000, 130, 9, 0, "midShift");
      applyStimulus(24'h000000, 90, 0, 0, "zeroCnt0");
      applyStimulus(24'h123456, 90, 25, 0, "zeroCnt25");
      applyStimulus(24'h000400, 10, 14, 0, "uflow");
      applyStimulus(24'h000400, 13, 14, 0, "uflowEdge");
      applyStimulus(24'h000400, 14, 14, 0, "noUflowEdge");
      applyStimulus(24'h00C000, 130, 9, 3, "backpressure");

      // Abort during the second shift cycle: nothing may come out afterwards.
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_mant  = 24'h000400;
      bus.in_exp   = 8'd50;
      bus.in_cnt   = 5'd14;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("midRst_inReady", 32'(bus.in_ready), 32'd1);
      checkOutput("midRst_outValid", 32'(bus.out_valid), 32'd0);
      checkOutput("midRst_mant", 32'(bus.out_mant), 32'd0);
      checkOutput("midRst_exp", 32'(bus.out_exp), 32'd0);
      checkOutput("midRst_zero", 32'(bus.out_zero), 32'd0);
      checkOutput("midRst_uflow", 32'(bus.out_uflow), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      seenValid = 0;
      repeat (10) begin
         @(posedge clk);
         #1;
         if (bus.out_valid) seenValid++;
      end
      checkOutput("midRst_noResult", 32'(seenValid), 32'd0);

      for (int i = 0; i < 40; i++) begin
         rm = N'($urandom) >> $urandom_range(0, N - 1);
         if (rm == '0) rm = 24'h000001;
         rc = leadCount(rm);
         if ($urandom_range(0, 7) == 0) rc = $urandom_range(0, 31);
         re = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 30) : $urandom_range(0, 255);
         applyStimulus(rm, re, rc, $urandom_range(0, 2), "random");
         if (rc == leadCount(rm)) begin
            checkOutput("random_msbSet", 32'(bus.out_mant[N-1]), 32'd1);
         end
      end

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end
endmodule
